// File: rtl/edfic_if.sv
// Handshake bundle between the EDF interrupt controller, its config master and the core.
// The slave side is the controller; the master side is the bus/core driving config and claims.
interface edfic_if #(
  parameter int unsigned NrIrqs  = 8,
  parameter int unsigned TsWidth = 24,
  parameter int unsigned TsClip  = 0
);
  localparam int unsigned IdWidth    = $clog2(NrIrqs);
  localparam int unsigned OutTsWidth = TsWidth + TsClip;

  logic                  cfg_req_i;
  logic                  cfg_we_i;
  logic [31:0]           cfg_addr_i;
  logic [31:0]           cfg_wdata_i;
  logic [31:0]           cfg_rdata_o;
  logic                  irq_valid_o;
  logic [IdWidth-1:0]    irq_id_o;
  logic [OutTsWidth-1:0] irq_dl_o;
  logic                  irq_ack_i;
  logic [IdWidth-1:0]    irq_id_i;
  logic                  irq_cpl_i;
  logic [IdWidth-1:0]    irq_cpl_id_i;
  logic                  miss_o;

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  irq_ack_i, irq_id_i, irq_cpl_i, irq_cpl_id_i,
    output cfg_rdata_o, irq_valid_o, irq_id_o, irq_dl_o, miss_o
  );

  modport master (
    output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output irq_ack_i, irq_id_i, irq_cpl_i, irq_cpl_id_i,
    input  cfg_rdata_o, irq_valid_o, irq_id_o, irq_dl_o, miss_o
  );
endinterface

// File: rtl/edfic_sched.sv
// EDF interrupt controller: per-line gateways, claim/complete tracking, preemption threshold
// against in-service lines, registered winner output and deadline-miss detection.
module edfic_sched #(
  parameter int unsigned NrIrqs   = 8,
  parameter int unsigned TsWidth  = 24,
  parameter int unsigned TsClip   = 0,
  parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [63:0]       mtime_i,
  input  logic [NrIrqs-1:0] irq_i,
  edfic_if.slave            bus
);
  localparam int unsigned OutTsWidth = TsWidth + TsClip;
  localparam int unsigned IdWidth    = $clog2(NrIrqs);
  localparam int unsigned DlWidth    = TsWidth - 1;

  typedef logic [TsWidth-1:0] ts_t;
  typedef logic [DlWidth-1:0] dl_t;

  logic [NrIrqs-1:0]     ie_q, ie_d, ip_q, ip_d, type_q, type_d, pol_q, pol_d;
  logic [NrIrqs-1:0]     miss_q, miss_d, act_q, act_d, prev_q;
  ts_t                   ts_q [NrIrqs];
  ts_t                   ts_d [NrIrqs];
  dl_t                   dl_q [NrIrqs];
  dl_t                   dl_d [NrIrqs];
  logic [15:0]           miss_cnt_q, miss_cnt_d;
  logic                  valid_q, valid_d, miss_pulse_q, miss_pulse_d;
  logic [IdWidth-1:0]    id_q, id_d;
  logic [OutTsWidth-1:0] odl_q, odl_d;
  logic [31:0]           rdata_q, rdata_d;

  ts_t                   now_s, min_act_s, win_rel_s, win_ts_s;
  ts_t                   rel_s [NrIrqs];
  logic                  any_act_s, win_found_s, wr_s, rd_s, stat_sel_s, ack_ok_s;
  logic [IdWidth-1:0]    win_id_s;
  logic [NrIrqs-1:0]     elig_s, gw_set_s, new_miss_s, line_sel_s;
  logic [31:0]           off_s;
  logic                  unused_s;

  function automatic logic [31:0] pack_line(input logic [5:0] flags, input dl_t dl);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[5:0] = flags;
    w[8 +: DlWidth] = dl;
    return w;
  endfunction

  assign unused_s = ^{mtime_i, bus.cfg_wdata_i};

  // Config access decode and claim acceptance.
  always_comb begin
    off_s      = bus.cfg_addr_i - BaseAddr;
    wr_s       = bus.cfg_req_i & bus.cfg_we_i;
    rd_s       = bus.cfg_req_i & ~bus.cfg_we_i;
    stat_sel_s = (off_s == 32'(4 * NrIrqs));
    ack_ok_s   = 1'b0;
    for (int i = 0; i < NrIrqs; i++) begin
      line_sel_s[i] = (off_s == 32'(4 * i));
      ack_ok_s = ack_ok_s | (bus.irq_ack_i & (bus.irq_id_i == IdWidth'(i)) & ip_q[i]);
    end
  end

  // Relative deadlines, in-service threshold and earliest-deadline winner (lowest id on ties).
  always_comb begin
    now_s     = mtime_i[TsClip +: TsWidth];
    any_act_s = 1'b0;
    min_act_s = '1;
    for (int i = 0; i < NrIrqs; i++) begin
      rel_s[i]  = ts_q[i] - now_s;
      any_act_s = any_act_s | act_q[i];
      if (act_q[i] && (rel_s[i] < min_act_s)) min_act_s = rel_s[i];
      else min_act_s = min_act_s;
    end
    win_found_s = 1'b0;
    win_id_s    = '0;
    win_rel_s   = '1;
    win_ts_s    = '0;
    for (int i = 0; i < NrIrqs; i++) begin
      elig_s[i] = ie_q[i] & ip_q[i] & (~any_act_s | (rel_s[i] < min_act_s));
      if (elig_s[i] && (!win_found_s || (rel_s[i] < win_rel_s))) begin
        win_found_s = 1'b1;
        win_id_s    = IdWidth'(i);
        win_rel_s   = rel_s[i];
        win_ts_s    = ts_q[i];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Per-line next state; later assignments take priority: cfg write, ack, cpl, gateway, miss.
  always_comb begin
    ie_d = ie_q; ip_d = ip_q; type_d = type_q; pol_d = pol_q;
    miss_d = miss_q; act_d = act_q; ts_d = ts_q; dl_d = dl_q;
    for (int i = 0; i < NrIrqs; i++) begin
      if (type_q[i]) gw_set_s[i] = pol_q[i] ? (prev_q[i] & ~irq_i[i]) : (irq_i[i] & ~prev_q[i]);
      else gw_set_s[i] = (irq_i[i] ^ pol_q[i]) & ~ip_q[i] & ~act_q[i];
      new_miss_s[i] = (ip_q[i] | act_q[i]) & rel_s[i][TsWidth-1] & ~miss_q[i];
      if (wr_s && line_sel_s[i]) begin
        ie_d[i]   = bus.cfg_wdata_i[0];
        ip_d[i]   = bus.cfg_wdata_i[1];
        type_d[i] = bus.cfg_wdata_i[2];
        pol_d[i]  = bus.cfg_wdata_i[3];
        miss_d[i] = miss_q[i] & ~bus.cfg_wdata_i[4];
        dl_d[i]   = bus.cfg_wdata_i[8 +: DlWidth];
        if (bus.cfg_wdata_i[1]) ts_d[i] = {1'b0, bus.cfg_wdata_i[8 +: DlWidth]} + now_s;
        else ts_d[i] = ts_q[i];
      end else begin
        dl_d[i] = dl_q[i];
      end
      if (ack_ok_s && (bus.irq_id_i == IdWidth'(i))) begin
        ip_d[i]  = 1'b0;
        act_d[i] = 1'b1;
      end else begin
        act_d[i] = act_d[i];
      end
      if (bus.irq_cpl_i && (bus.irq_cpl_id_i == IdWidth'(i))) act_d[i] = 1'b0;
      else act_d[i] = act_d[i];
      if (gw_set_s[i]) begin
        ip_d[i] = 1'b1;
        ts_d[i] = {1'b0, dl_q[i]} + now_s;
      end else begin
        ip_d[i] = ip_d[i];
      end
      miss_d[i] = miss_d[i] | new_miss_s[i];
    end
  end

  // Registered outputs: winner (suppressed for the cycle after a claim), miss pulse/count, read data.
  always_comb begin
    valid_d      = win_found_s & ~ack_ok_s;
    id_d         = valid_d ? win_id_s : '0;
    odl_d        = valid_d ? (OutTsWidth'(win_ts_s) << TsClip) : '0;
    miss_pulse_d = |new_miss_s;
    if (wr_s && stat_sel_s) miss_cnt_d = 16'h0000;
    else if (miss_pulse_d && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'h0001;
    else miss_cnt_d = miss_cnt_q;
    rdata_d = 32'h0000_0000;
    if (rd_s) begin
      for (int i = 0; i < NrIrqs; i++) begin
        if (line_sel_s[i])
          rdata_d = pack_line({act_q[i], miss_q[i], pol_q[i], type_q[i], ip_q[i], ie_q[i]}, dl_q[i]);
        else rdata_d = rdata_d;
      end
      if (stat_sel_s) rdata_d = {16'h0000, miss_cnt_q};
      else rdata_d = rdata_d;
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // State registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ie_q <= '0; ip_q <= '0; type_q <= '0; pol_q <= '0;
      miss_q <= '0; act_q <= '0; prev_q <= '0;
      for (int i = 0; i < NrIrqs; i++) begin
        ts_q[i] <= '0;
        dl_q[i] <= '0;
      end
      miss_cnt_q <= 16'h0000; valid_q <= 1'b0; miss_pulse_q <= 1'b0;
      id_q <= '0; odl_q <= '0; rdata_q <= 32'h0000_0000;
    end else begin
      ie_q <= ie_d; ip_q <= ip_d; type_q <= type_d; pol_q <= pol_d;
      miss_q <= miss_d; act_q <= act_d; prev_q <= irq_i;
      ts_q <= ts_d; dl_q <= dl_d;
      miss_cnt_q <= miss_cnt_d; valid_q <= valid_d; miss_pulse_q <= miss_pulse_d;
      id_q <= id_d; odl_q <= odl_d; rdata_q <= rdata_d;
    end
  end

  assign bus.cfg_rdata_o = rdata_q;
  assign bus.irq_valid_o = valid_q;
  assign bus.irq_id_o    = id_q;
  assign bus.irq_dl_o    = odl_q;
  assign bus.miss_o      = miss_pulse_q;
endmodule

// File: doc/edfic_sched.md
Name: edfic_sched

Overview:
Next-generation EDF interrupt controller. It adds four things:
- a registered arbitration output;
- claim/complete tracking of in-service interrupts;
- EDF preemption threshold: only an interrupt with a strictly earlier deadline than every in-service interrupt is presented;
- per-line deadline-miss detection with a saturating miss counter.

It sits between the interrupt sources/mtime and the core's interrupt interface, configured over the cfg bus.

Parameters:
NrIrqs, 8, number of interrupt lines (>=2)
TsWidth, 24, timestamp width in bits; legal range 2..25
TsClip, 0, mtime LSBs dropped; now = mtime_i[TsClip +: TsWidth]
BaseAddr, 0, byte base address of register map
OutTsWidth, TsWidth+TsClip, localparam; width of irq_dl_o
IdWidth, $clog2(NrIrqs), localparam; line id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
cfg_req_i  in  1  config access strobe
cfg_we_i  in  1  1=write, 0=read
cfg_addr_i  in  32  byte address
cfg_wdata_i  in  32  write data
cfg_rdata_o  out  32  read data, registered, valid cycle after read req
mtime_i  in  64  free-running time
irq_i  in  NrIrqs  raw interrupt inputs
irq_valid_o  out  1  registered: a line is presentable
irq_id_o  out  IdWidth  registered winner id
irq_dl_o  out  OutTsWidth  registered winner absolute deadline, {ts, TsClip zeros}
irq_ack_i  in  1  claim strobe
irq_id_i  in  IdWidth  id being claimed
irq_cpl_i  in  1  completion strobe
irq_cpl_id_i  in  IdWidth  id being completed
miss_o  out  1  one-cycle pulse on any new deadline miss

Behaviour:
- Reset: single clock, clk_i. Synchronous, active-low rst_ni clears all state; every output is 0 in the first cycle after reset. Reset mid-operation discards pending, active, miss and counter state.
- Register map, offset = cfg_addr_i - BaseAddr:
  - Line i at 4*i:
    - [0] ie
    - [1] ip
    - [2] trig_type (1=edge, 0=level)
    - [3] trig_pol (0=rising/high, 1=falling/low)
    - [4] miss (read; write-1-clears)
    - [5] act (read-only)
    - [8 +: TsWidth-1] dl
  - Status at 4*NrIrqs: [15:0] miss_cnt; any write clears it.
  - Unmapped reads return 0; unmapped writes are ignored. Unused read bits are 0.
- Time arithmetic: all modulo 2^TsWidth.
  - rel_i = ts_i - now.
  - Compare "earlier" by unsigned rel.
  - Missed when rel MSB = 1.
  - dl is TsWidth-1 bits, so a fresh ts is never missed.
- Gateway:
  - Edge mode: previous irq_i sample register; a qualifying edge sampled at edge N sets ip after edge N.
  - Level mode: active level sets ip while ip=0 and act=0.
  - On gateway set: ip=1, ts = {0,dl} + now.
  - A software write with wdata[1]=1 also loads ts.
- Eligibility, per line: ie & ip & (no act line, or rel_i < min rel over act lines).
- Arbitration: among eligible lines, smallest rel wins; ties go to the lowest id. The winner registers into irq_valid_o/id/dl one edge later. An interrupt sampled at edge N therefore gives irq_valid_o=1 after edge N+1.
- Claim: irq_ack_i with ip[irq_id_i]=1 clears ip and sets act; otherwise the claim is ignored. irq_valid_o is forced 0 for the cycle after an accepted ack (bubble), then re-arbitrates.
- Complete: irq_cpl_i clears act[irq_cpl_id_i]; completion of a non-act line is ignored. The threshold recomputes the next cycle.
- Deadline miss: a line with (ip|act)=1, rel MSB=1 and miss=0 sets miss. miss_o pulses once per cycle in which at least one line newly misses. miss_cnt increments by 1 per such cycle and saturates at 0xFFFF. Miss does not alter ip, act or arbitration.
- Simultaneous events, same line same cycle:
  - Gateway set beats cfg write for ip/ts.
  - Gateway set beats ack: line stays pending with new ts, act still set by the ack.
  - Cfg W1C of miss and a new miss: miss stays 1.
  - Ack and cpl of the same id: act=0, ip=0.

Test Plan:
1. NrIrqs=4, TsWidth=24, mtime=1000; dl1=100, dl2=50, both edge/ie. Rise irq_i[1], irq_i[2] sampled at edge N -> after edge N+1: irq_valid_o=1, irq_id_o=2, irq_dl_o=1050.
2. Continue test 1: ack id 2 -> bubble, then irq_valid_o=0 (1100 not earlier than 1050). cpl id 2 -> next cycle irq_valid_o=1, id=1, dl=1100.
3. dl=10, trigger at mtime=0, no ack. mtime=10 -> no miss. mtime=11 -> miss_o single pulse; line read shows miss=1; status reads 1. Write 1 to bit4 -> miss=0.
4. Wrap: mtime=0xFFFFF0. Line0 dl=0x20 (ts 0x000010), line1 dl=0x08 (ts 0xFFFFF8) -> winner id 1. Advance to mtime=0x000005 -> line1 miss, line0 not missed.
5. Level-high line: hold irq_i high, ack -> ip stays 0 while act. cpl with level still high -> ip=1 and irq_valid_o=1 two cycles later.
6. Pending line, irq_valid_o=1, rst_ni=0 for one cycle -> all outputs 0, all registers read 0, miss_cnt=0.
